// File: rtl/sprite_line_eval.sv
// rtl/sprite_line_eval.sv - per-scanline sprite selector emitting visible sprite slots
module sprite_line_eval #(
    parameter int NUM_SPRITES  = 30,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_LOG2  = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_line_start,
    input  logic [9:0]             i_next_line,
    output logic [4:0]             o_desc_idx,
    input  logic [31:0]            i_desc_data,
    output logic                   o_slot_valid,
    input  logic                   i_slot_ready,
    output logic [5:0]             o_slot_image,
    output logic [9:0]             o_slot_x,
    output logic [SPRITE_LOG2-1:0] o_slot_row,
    output logic                   o_busy,
    output logic                   o_line_done,
    output logic [3:0]             o_hit_count,
    output logic                   o_overflow
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_EMIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_line;
    logic [4:0]  r_idx;
    logic [3:0]  r_hit_count;
    logic        r_overflow;
    logic [5:0]  r_slot_image;
    logic [9:0]  r_slot_x;
    logic [SPRITE_LOG2-1:0] r_slot_row;

    logic [5:0]  w_img;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic [10:0] w_diff;
    logic        w_hit;
    logic        w_room;
    logic        w_last;
    logic        w_advance;
    logic        w_unused_desc;

    assign w_img         = i_desc_data[25:20];
    assign w_x           = i_desc_data[19:10];
    assign w_y           = i_desc_data[9:0];
    assign w_unused_desc = ^i_desc_data[31:26];

    // A negative difference (bit 10) means the sprite starts below this line; no wrap at 1023.
    assign w_diff = {1'b0, r_line} - {1'b0, w_y};
    assign w_hit  = !w_diff[10] && (w_diff[9:SPRITE_LOG2] == '0) && (w_img != 6'd0);
    assign w_room = r_hit_count < 4'(MAX_PER_LINE);
    assign w_last = r_idx == 5'(NUM_SPRITES - 1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_advance    = 1'b0;
        o_busy       = 1'b1;
        o_line_done  = 1'b0;
        o_slot_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_line_start) w_next = S_FETCH;
            end
            S_FETCH: w_next = S_EVAL;
            S_EVAL: begin
                if (w_hit && w_room) w_next = S_EMIT;
                else                 w_advance = 1'b1;
            end
            S_EMIT: begin
                o_slot_valid = 1'b1;
                if (i_slot_ready) w_advance = 1'b1;
            end
            S_DONE: begin
                o_line_done = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_advance) w_next = w_last ? S_DONE : S_FETCH;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_line       <= 10'd0;
            r_idx        <= 5'd0;
            r_hit_count  <= 4'd0;
            r_overflow   <= 1'b0;
            r_slot_image <= 6'd0;
            r_slot_x     <= 10'd0;
            r_slot_row   <= '0;
        end else begin
            if (r_state == S_IDLE && i_line_start) begin
                r_line      <= i_next_line;
                r_idx       <= 5'd0;
                r_hit_count <= 4'd0;
                r_overflow  <= 1'b0;
            end
            if (r_state == S_EVAL && w_hit) begin
                if (w_room) begin
                    r_slot_image <= w_img;
                    r_slot_x     <= w_x;
                    r_slot_row   <= w_diff[SPRITE_LOG2-1:0];
                end else begin
                    r_overflow <= 1'b1;
                end
            end
            // Entry to EMIT requires room, so this increment never passes MAX_PER_LINE.
            if (r_state == S_EMIT && i_slot_ready) r_hit_count <= r_hit_count + 4'd1;
            if (w_advance && !w_last) r_idx <= r_idx + 5'd1;
        end
    end

    assign o_desc_idx   = r_idx;
    assign o_hit_count  = r_hit_count;
    assign o_overflow   = r_overflow;
    assign o_slot_image = r_slot_image;
    assign o_slot_x     = r_slot_x;
    assign o_slot_row   = r_slot_row;

endmodule

// File: tb/tb_sprite_line_eval.sv
// tb/tb_sprite_line_eval.sv - scoreboard bench for sprite_line_eval
module tb_sprite_line_eval;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        line_start;
    logic [9:0]  next_line;
    logic [4:0]  desc_idx;
    logic [31:0] desc_data;
    logic        slot_valid;
    logic        slot_ready;
    logic [5:0]  slot_image;
    logic [9:0]  slot_x;
    logic [4:0]  slot_row;
    logic        busy;
    logic        line_done;
    logic [3:0]  hit_count;
    logic        overflow;

    logic [31:0] mem [0:31];
    int cyc = 0, start_cyc = 0, done_cnt = 0, n_tests = 0, n_fail = 0;

    typedef struct packed {
        logic [3:0] hc;
        logic       ov;
        logic       chk;
        logic [7:0] lat;
    } done_t;

    logic [20:0] exp_q [$];
    done_t       done_q [$];

    always #5 clk = ~clk;

    sprite_line_eval dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_line_start (line_start),
        .i_next_line  (next_line),
        .o_desc_idx   (desc_idx),
        .i_desc_data  (desc_data),
        .o_slot_valid (slot_valid),
        .i_slot_ready (slot_ready),
        .o_slot_image (slot_image),
        .o_slot_x     (slot_x),
        .o_slot_row   (slot_row),
        .o_busy       (busy),
        .o_line_done  (line_done),
        .o_hit_count  (hit_count),
        .o_overflow   (overflow)
    );

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        desc_data <= mem[desc_idx];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] img, input logic [9:0] x, input logic [9:0] y);
        return {6'd0, img, x, y};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    endtask

    task automatic push_slot(input logic [5:0] img, input logic [9:0] x, input logic [4:0] row);
        exp_q.push_back({img, x, row});
    endtask

    task automatic push_done(input logic [3:0] hc, input logic ov, input logic chk, input logic [7:0] lat);
        done_t d;
        d.hc = hc; d.ov = ov; d.chk = chk; d.lat = lat;
        done_q.push_back(d);
    endtask

    task automatic start_line(input logic [9:0] ln);
        next_line  = ln;
        line_start = 1'b1;
        start_cyc  = cyc;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        for (int k = 0; k < 400 && done_cnt == d0; k++) tick();
        check(nm, 32'(done_cnt != d0), 32'd1);
        check({nm, "_slots_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_line(input logic [9:0] ln, input logic [3:0] hc, input logic ov, input logic [7:0] lat, input string nm);
        int d0;
        d0 = done_cnt;
        push_done(hc, ov, 1'b1, lat);
        start_line(ln);
        wait_done(d0, nm);
    endtask

    // Scoreboard monitor: pops expected records on every accepted slot and every line_done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (slot_valid && slot_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_slot: got %0h expected none", {slot_image, slot_x, slot_row});
                end else begin
                    check("slot", 32'({slot_image, slot_x, slot_row}), 32'(exp_q.pop_front()));
                end
            end
            if (line_done) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_line_done: got 1 expected 0");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("hit_count", 32'(hit_count), 32'(d.hc));
                    check("overflow", 32'(overflow), 32'(d.ov));
                    if (d.chk) check("latency", 32'(cyc - start_cyc + 1), 32'(d.lat));
                end
                done_cnt = done_cnt + 1;
            end
        end
    end

    initial begin
        int d0;
        reset_n    = 1'b0;
        line_start = 1'b0;
        next_line  = 10'd0;
        slot_ready = 1'b1;
        clear_mem();
        repeat (3) tick();
        check("rst_slot_valid", 32'(slot_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_desc_idx", 32'(desc_idx), 32'd0);
        check("rst_slot_fields", 32'({slot_image, slot_x, slot_row}), 32'd0);
        reset_n = 1'b1;
        tick();

        // Empty table: 1 + 2*30 + 0 + 1 cycles.
        run_line(10'd100, 4'd0, 1'b0, 8'd62, "empty");

        mem[3] = mk(6'd5, 10'd200, 10'd90);
        push_slot(6'd5, 10'd200, 5'd10);
        run_line(10'd100, 4'd1, 1'b0, 8'd63, "single_row10");
        run_line(10'd122, 4'd0, 1'b0, 8'd62, "single_row32_miss");
        push_slot(6'd5, 10'd200, 5'd31);
        run_line(10'd121, 4'd1, 1'b0, 8'd63, "single_row31");

        clear_mem();
        for (int k = 0; k < 10; k++) mem[k] = mk(6'd1, 10'(k * 10), 10'd50);
        for (int k = 0; k < 8; k++) push_slot(6'd1, 10'(k * 10), 5'd10);
        run_line(10'd60, 4'd8, 1'b1, 8'd70, "overflow");

        // Back-pressure on the first hit.
        clear_mem();
        mem[4]  = mk(6'd7, 10'd300, 10'd100);
        mem[20] = mk(6'd9, 10'd5, 10'd96);
        push_slot(6'd7, 10'd300, 5'd10);
        push_slot(6'd9, 10'd5, 5'd14);
        push_done(4'd2, 1'b0, 1'b0, 8'd0);
        slot_ready = 1'b0;
        d0 = done_cnt;
        start_line(10'd110);
        for (int k = 0; k < 100 && !slot_valid; k++) tick();
        check("stall_valid_seen", 32'(slot_valid), 32'd1);
        for (int k = 0; k < 20; k++) begin
            check("stall_valid", 32'(slot_valid), 32'd1);
            check("stall_fields", 32'({slot_image, slot_x, slot_row}), 32'({6'd7, 10'd300, 5'd10}));
            tick();
        end
        slot_ready = 1'b1;
        wait_done(d0, "stall");

        // No wrap past row 1023; a second line_start while busy is ignored.
        clear_mem();
        mem[0] = mk(6'd3, 10'd40, 10'd1000);
        d0 = done_cnt;
        push_done(4'd0, 1'b0, 1'b1, 8'd62);
        start_line(10'd5);
        repeat (5) tick();
        next_line  = 10'd1010;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_done(d0, "nowrap");
        repeat (80) tick();
        check("single_line_done", 32'(done_cnt - d0), 32'd1);

        // Reset while holding a slot in EMIT.
        clear_mem();
        mem[2]  = mk(6'd4, 10'd100, 10'd200);
        mem[20] = mk(6'd6, 10'd150, 10'd210);
        push_slot(6'd4, 10'd100, 5'd20);
        push_slot(6'd6, 10'd150, 5'd10);
        push_done(4'd2, 1'b0, 1'b1, 8'd64);
        start_line(10'd220);
        for (int k = 0; k < 100 && hit_count != 4'd1; k++) tick();
        slot_ready = 1'b0;
        for (int k = 0; k < 100 && !slot_valid; k++) tick();
        check("pre_rst_valid", 32'(slot_valid), 32'd1);
        check("pre_rst_hit_count", 32'(hit_count), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(slot_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_hit_count", 32'(hit_count), 32'd0);
        exp_q.delete();
        done_q.delete();
        repeat (3) tick();
        reset_n    = 1'b1;
        slot_ready = 1'b1;
        tick();
        check("post_rst_no_done", 32'(done_cnt), 32'(d0 + 1));
        push_slot(6'd4, 10'd100, 5'd20);
        push_slot(6'd6, 10'd150, 5'd10);
        run_line(10'd220, 4'd2, 1'b0, 8'd64, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
